// File: rtl/hog_pkg.sv
// Shared sizing helpers for the HOG line/window blocks.
// Holds the pixel-width computation and a constant-safe clog2.
package hog_pkg;

    // Bits needed to hold values 0..v-1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits per pixel across all channels
    function automatic int pix_bits(input int pw, input int ch);
        return pw * ch;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: a single port address shared by
// the synchronous write and the asynchronous read.
module line_ram import hog_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 854
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   addr,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the word stored one line earlier at this column
    assign rdata = mem[addr];

    // Overwrite the column with the word moving down one line
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_buff.sv
// Sliding WIN_W x WIN_H pixel window over a raster stream,
// with border masking, end-of-line flag and one output register.
module window_buff import hog_pkg::*; #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int MAX_LINE    = 854,
    parameter int WIN_W       = 3,
    parameter int WIN_H       = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [pix_bits(PIXEL_WIDTH,CHANNELS)-1:0] s_data,
    input  logic                                    s_sof,
    input  logic [clog2(MAX_LINE+1)-1:0]            line_width,
    input  logic                                    emit_all,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [WIN_W*WIN_H*pix_bits(PIXEL_WIDTH,CHANNELS)-1:0] m_window,
    output logic                                    m_border,
    output logic                                    m_eol,
    output logic                                    err
);

    localparam int PB = pix_bits(PIXEL_WIDTH, CHANNELS);
    localparam int XW = clog2(MAX_LINE + 1);
    localparam int AW = clog2(MAX_LINE);
    localparam int YW = clog2(WIN_H);
    localparam int NW = WIN_W * WIN_H * PB;
    localparam int NL = WIN_H - 1;

    localparam logic [XW-1:0] MAX_L = XW'(MAX_LINE);
    localparam logic [XW-1:0] MIN_L = XW'(WIN_W);
    localparam logic [XW-1:0] X_FUL = XW'(WIN_W - 1);
    localparam logic [YW-1:0] Y_TOP = YW'(WIN_H - 1);

    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [XW-1:0]    l_q;
    logic [NW-1:0]    sh_q;
    logic [NW-1:0]    sh_nxt;
    logic [NW-1:0]    win_nxt;
    logic [NL*PB-1:0] rd_v;
    logic [WIN_H*PB-1:0] col_v;

    logic            accept;
    logic            bad_w;
    logic [XW-1:0]   l_cur;
    logic [XW-1:0]   pos_x;
    logic [YW-1:0]   pos_y;
    logic            last;
    logic            full;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign bad_w   = (line_width < MIN_L) || (line_width > MAX_L);
    assign l_cur   = s_sof ? (bad_w ? MAX_L : line_width) : l_q;
    assign pos_x   = s_sof ? '0 : x_q;
    assign pos_y   = s_sof ? '0 : y_q;
    assign last    = (pos_x == l_cur - XW'(1));
    assign full    = (pos_x >= X_FUL) && (pos_y == Y_TOP);

    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [PB-1:0] wd;
        if (k == 0) begin : g_first
            assign wd = s_data;
        end else begin : g_next
            assign wd = rd_v[(k-1)*PB +: PB];
        end
        line_ram #(
            .WIDTH (PB),
            .DEPTH (MAX_LINE)
        ) u_line (
            .clk   (clk),
            .we    (accept),
            .addr  (pos_x[AW-1:0]),
            .wdata (wd),
            .rdata (rd_v[k*PB +: PB])
        );
    end

    // Build the incoming column, shift it in and mask off-frame elements
    always_comb begin
        col_v   = '0;
        sh_nxt  = sh_q;
        win_nxt = '0;
        col_v[NL*PB +: PB] = s_data;
        for (int j = 0; j < NL; j++) begin
            col_v[j*PB +: PB] = rd_v[(NL-1-j)*PB +: PB];
        end
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
                if (c < WIN_W - 1) begin
                    sh_nxt[(r*WIN_W+c)*PB +: PB] =
                        sh_q[(r*WIN_W+c+1)*PB +: PB];
                end else begin
                    sh_nxt[(r*WIN_W+c)*PB +: PB] = col_v[r*PB +: PB];
                end
                if ((int'(pos_x) + c >= WIN_W - 1) &&
                    (int'(pos_y) + r >= WIN_H - 1)) begin
                    win_nxt[(r*WIN_W+c)*PB +: PB] =
                        sh_nxt[(r*WIN_W+c)*PB +: PB];
                end
            end
        end
    end

    // Track position, line length and error; register the output window
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            l_q      <= MAX_L;
            sh_q     <= '0;
            err      <= 1'b0;
            m_valid  <= 1'b0;
            m_window <= '0;
            m_border <= 1'b0;
            m_eol    <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept) begin
                x_q  <= last ? '0 : pos_x + XW'(1);
                y_q  <= (last && pos_y != Y_TOP) ? pos_y + YW'(1) : pos_y;
                l_q  <= l_cur;
                sh_q <= sh_nxt;
                if (s_sof && bad_w) begin
                    err <= 1'b1;
                end
                if (full || emit_all) begin
                    m_valid  <= 1'b1;
                    m_window <= win_nxt;
                    m_border <= !full;
                    m_eol    <= last;
                end
            end
        end
    end

endmodule

// File: doc/window_buff.md
WINDOW_BUFF -- requirements
Module: window_buff

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 1, channels per pixel; PIX_BITS = PIXEL_WIDTH*CHANNELS.
REQ-003 SHALL have parameter MAX_LINE, default 854, maximum supported line length in pixels.
REQ-004 SHALL have parameters WIN_W and WIN_H, default 3 and 3, window width and height, each >= 2.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: s_valid  in  1; s_ready  out  1; s_data  in  PIX_BITS  pixel; s_sof  in  1  marks pixel (0,0) of a frame.
REQ-007 SHALL have port line_width  in  clog2(MAX_LINE+1)  runtime line length, sampled with each accepted s_sof pixel.
REQ-008 SHALL have port emit_all  in  1  quasi-static mode: 0 = only full windows, 1 = every pixel yields a window.
REQ-009 SHALL have ports: m_valid  out  1; m_ready  in  1; m_window  out  WIN_W*WIN_H*PIX_BITS.
REQ-010 SHALL have ports: m_border  out  1  window overlaps frame edge; m_eol  out  1  window's newest pixel is the last of its line; err  out  1  sticky bad line_width.

Function
REQ-011 Pixel accepted when s_valid && s_ready; s_ready = !m_valid || m_ready (one output register stage, no combinational path from s_valid to m_valid).
REQ-012 Window for accepted pixel (x,y) SHALL appear on m_window with m_valid the cycle after acceptance; newest pixel occupies bottom-right.
REQ-013 Element (r,c) SHALL sit at m_window[((r*WIN_W)+c)*PIX_BITS +: PIX_BITS]; r=0 oldest row, c=0 leftmost; element maps to frame pixel (x-WIN_W+1+c, y-WIN_H+1+r).
REQ-014 Column counter x SHALL count 0..L-1 and wrap to 0; row counter y SHALL increment on wrap and saturate at WIN_H-1 (no frame-size counter).
REQ-015 Accepted pixel with s_sof=1 SHALL be (0,0) regardless of counter state; prior partial frame abandoned, no window mixes rows of two frames in full-window mode.
REQ-016 L SHALL be line_width latched at s_sof; if line_width < WIN_W or > MAX_LINE, L = MAX_LINE and err set until rst.
REQ-017 Before the first s_sof after reset, L SHALL be MAX_LINE.
REQ-018 Full window: x >= WIN_W-1 and y >= WIN_H-1; m_border=0.
REQ-019 emit_all=0: non-full positions SHALL be accepted and dropped (no m_valid).
REQ-020 emit_all=1: non-full positions SHALL be emitted with m_border=1 and every element outside the frame (negative coordinate) forced to zero.
REQ-021 m_eol SHALL equal (x == L-1) for the emitted window.
REQ-022 While m_valid && !m_ready, m_window, m_border, m_eol SHALL hold stable; no pixel lost or duplicated.
REQ-023 Line storage: WIN_H-1 lines of MAX_LINE x PIX_BITS, addressed by x; on acceptance, line k receives line k-1's word at x, line 0 receives s_data.
REQ-024 Window shift register SHALL shift one column per acceptance, new column = {line WIN_H-2 .. line 0 at x, s_data}.

Reset
REQ-025 On rst: m_valid=0, m_window=0, m_border=0, m_eol=0, err=0, x=0, y=0, L=MAX_LINE.
REQ-026 Reset mid-frame SHALL discard window state; line memory contents need not be cleared (masking/saturation guarantees no stale data in full windows).
REQ-027 s_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-028 Shared package/header hog_pkg SHALL hold PIX_BITS computation and clog2 helper used by all HOG line/window blocks.
REQ-029 One sub-module line_ram (single-line, one write port, one read port, same address) SHALL be instantiated WIN_H-1 times.
REQ-030 Implementation SHALL be 120-400 lines RTL, fully parametric, no vendor primitives.

Verification (WIN 3x3, CHANNELS=1, line_width=4, pixel value = index+1, m_ready=1 unless stated)
REQ-031 16-pixel frame, s_sof on first, emit_all=0 -> exactly 4 windows; first after pixel 11 accepted = {1,2,3,5,6,7,9,10,11}, m_eol=0; second m_eol=1.
REQ-032 Same frame, emit_all=1 -> 16 windows; first = eight zeros, bottom-right 1, m_border=1; window for pixel 11 m_border=0.
REQ-033 m_ready low 5 cycles with s_valid held high -> s_ready low from cycle after held window, m_window unchanged, all 4 windows delivered in order.
REQ-034 s_sof asserted on 7th pixel -> counters restart; emit_all=0 windows only after new frame's pixel (2,2), contents all new-frame values.
REQ-035 line_width=2 at s_sof -> err=1, L=854, first full window at pixel index 2*854+2.
REQ-036 rst pulsed mid-frame -> next cycle m_valid=0, s_ready=1; new frame after rst yields windows identical to REQ-031.
